// File: rtl/riscv_mem_wb_stage.sv
// riscv_mem_wb_stage: memory-access / write-back stage with an internal word-addressed DMEM.
// Optional misaligned-access trap is enabled with `define MEM_WB_MISALIGN_TRAP_EN.
module riscv_mem_wb_stage #(
    parameter int XLEN       = 32,
    parameter int DMEM_DEPTH = 32,
    parameter int ADDR_W     = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic [31:0]     ex_ir,
    input  logic [XLEN-1:0] ex_result,
    input  logic [XLEN-1:0] ex_rs2,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic            misalign
);
    typedef enum logic [1:0] {IDLE, ACCESS, WRITE} state_t;
    state_t state;
    logic [14:0] ir_q;
    logic [XLEN-1:0] res_q, rs2_q, word, lval, sdata;
    logic [XLEN-1:0] mem [DMEM_DEPTH];
    logic [6:0] op;
    logic [2:0] f3;
    logic [4:0] rd;
    logic [1:0] off;
    logic [ADDR_W-1:0] idx;
    logic [7:0] lb;
    logic [15:0] lh;
    logic [3:0] be;
    logic is_ld, is_st, is_wb, ld_ok, st_ok, mis, wr;
    logic unused_ir;
    assign unused_ir = ^ex_ir[31:15];
    assign op = ir_q[6:0];
    assign rd = ir_q[11:7];
    assign f3 = ir_q[14:12];
    assign off = res_q[1:0];
    assign idx = res_q[ADDR_W+1:2];
    assign word = mem[idx];
    assign ex_ready = state == IDLE;
    assign misalign = (state == ACCESS) & mis;
    always_comb begin
        is_ld = op == 7'b0000011;
        is_st = op == 7'b0100011;
        is_wb = op inside {7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111};
        ld_ok = is_ld & (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        st_ok = is_st & (f3 inside {3'b000, 3'b001, 3'b010});
        lb = word[{off, 3'b000} +: 8];
        lh = off[1] ? word[31:16] : word[15:0];
        lval = f3 == 3'b000 ? {{(XLEN-8){lb[7]}}, lb} :
               f3 == 3'b001 ? {{(XLEN-16){lh[15]}}, lh} :
               f3 == 3'b100 ? {{(XLEN-8){1'b0}}, lb} :
               f3 == 3'b101 ? {{(XLEN-16){1'b0}}, lh} : word;
        sdata = f3[1:0] == 2'b00 ? {4{rs2_q[7:0]}} :
                f3[1:0] == 2'b01 ? {2{rs2_q[15:0]}} : rs2_q;
        be = f3[1:0] == 2'b00 ? 4'b0001 << off :
             f3[1:0] == 2'b01 ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
`ifdef MEM_WB_MISALIGN_TRAP_EN
        mis = (ld_ok | st_ok) & ((f3[1:0] == 2'b01 & off[0]) | (f3[1:0] == 2'b10 & off != 2'b00));
`else
        mis = 1'b0;
`endif
        wr = ld_ok | is_wb;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            rf_we <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            ir_q <= '0;
            res_q <= '0;
            rs2_q <= '0;
            for (int i = 0; i < DMEM_DEPTH; i++) mem[i] <= '0;
        end else begin
            rf_we <= 1'b0;
            case (state)
                IDLE: if (ex_valid) begin
                    ir_q <= ex_ir[14:0];
                    res_q <= ex_result;
                    rs2_q <= ex_rs2;
                    state <= ACCESS;
                end
                ACCESS: begin
                    state <= IDLE;
                    if (!mis) begin
                        if (st_ok)
                            for (int b = 0; b < 4; b++)
                                if (be[b]) mem[idx][8*b +: 8] <= sdata[8*b +: 8];
                        if (wr) begin
                            state <= WRITE;
                            if (rd != 5'd0) begin
                                rf_we <= 1'b1;
                                rf_waddr <= rd;
                                rf_wdata <= is_ld ? lval : res_q;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
